// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: multi-cycle sequencer for the A/Q/M ALU datapath.
// Runs add, sub, Booth radix-2 multiply and non-restoring divide.
// Ports: clk, reset (async, active-low), start, op[1:0], abort,
//   datapath status q0/q_m1/a_sign; strobes ld_regs, add_en, sub_en,
//   shift_en, shift_left, qbit_en, qbit_val; iter, busy, done.
module alu_seq_ctrl #(
   parameter int N     = 8,
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic             abort,
   input  logic             q0,
   input  logic             q_m1,
   input  logic             a_sign,
   output logic             ld_regs,
   output logic             add_en,
   output logic             sub_en,
   output logic             shift_en,
   output logic             shift_left,
   output logic             qbit_en,
   output logic             qbit_val,
   output logic [CNT_W-1:0] iter,
   output logic             busy,
   output logic             done
);

   typedef enum logic [3:0] {
      S_IDLE, S_INIT, S_EXEC, S_EVAL, S_SHIFT,
      S_DADD, S_QBIT, S_CORR, S_DONE
   } state_t;

   localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);
   localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

   state_t           state, state_nxt;
   logic [1:0]       op_r, op_nxt;
   logic [CNT_W-1:0] iter_nxt;
   logic             last;

   assign last = (iter == LAST);
   assign busy = (state != S_IDLE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
         op_r  <= 2'b00;
         iter  <= '0;
      end else begin
         state <= state_nxt;
         op_r  <= op_nxt;
         iter  <= iter_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      op_nxt     = op_r;
      iter_nxt   = iter;
      ld_regs    = 1'b0;
      add_en     = 1'b0;
      sub_en     = 1'b0;
      shift_en   = 1'b0;
      shift_left = 1'b0;
      qbit_en    = 1'b0;
      qbit_val   = 1'b0;
      done       = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (start) begin
               state_nxt = S_INIT;
               op_nxt    = op;
            end
         end
         S_INIT: begin
            ld_regs  = 1'b1;
            iter_nxt = '0;
            if (!op_r[1])     state_nxt = S_EXEC;
            else if (!op_r[0]) state_nxt = S_EVAL;
            else              state_nxt = S_SHIFT;
         end
         S_EXEC: begin
            add_en    = ~op_r[0];
            sub_en    = op_r[0];
            state_nxt = S_DONE;
         end
         S_EVAL: begin
            // Booth recoding from the live {Q[0],Q[-1]} pair
            add_en    = ~q0 & q_m1;
            sub_en    = q0 & ~q_m1;
            state_nxt = S_SHIFT;
         end
         S_SHIFT: begin
            shift_en   = 1'b1;
            shift_left = op_r[0];
            if (op_r[0]) begin
               state_nxt = S_DADD;
            end else begin
               iter_nxt  = iter + ONE;
               state_nxt = last ? S_DONE : S_EVAL;
            end
         end
         S_DADD: begin
            // non-restoring: subtract while A >= 0, add back when negative
            sub_en    = ~a_sign;
            add_en    = a_sign;
            state_nxt = S_QBIT;
         end
         S_QBIT: begin
            qbit_en   = 1'b1;
            qbit_val  = ~a_sign;
            iter_nxt  = iter + ONE;
            state_nxt = last ? S_CORR : S_SHIFT;
         end
         S_CORR: begin
            add_en    = a_sign;
            state_nxt = S_DONE;
         end
         S_DONE: begin
            done      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
      // cancel drops straight to IDLE without a done pulse
      if (abort && state != S_IDLE && state != S_DONE) begin
         state_nxt = S_IDLE;
         iter_nxt  = '0;
      end
   end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: directed bench for the ALU sequencer.
// Includes a behavioural A/Q/M datapath so mul/div results can be checked.
module tb_alu_seq_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       start = 1'b0;
   logic [1:0] op = 2'b00;
   logic       abort = 1'b0;
   logic       q0, q_m1, a_sign;
   logic       ld_regs, add_en, sub_en, shift_en, shift_left;
   logic       qbit_en, qbit_val, busy, done;
   logic [2:0] iter;

   int n_cmp = 0;
   int n_bad = 0;

   // datapath model: 9-bit A, 8-bit Q, 9-bit M, Q[-1]
   logic [8:0] ma, mm;
   logic [7:0] mq;
   logic       mqm1;
   logic [7:0] opq;
   logic [8:0] opm;

   logic [11:0] obs, exp_v;

   always #5 clk = ~clk;

   alu_seq_ctrl #(.N(8), .CNT_W(3)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .abort(abort),
      .q0(q0), .q_m1(q_m1), .a_sign(a_sign),
      .ld_regs(ld_regs), .add_en(add_en), .sub_en(sub_en),
      .shift_en(shift_en), .shift_left(shift_left),
      .qbit_en(qbit_en), .qbit_val(qbit_val),
      .iter(iter), .busy(busy), .done(done)
   );

   assign q0     = mq[0];
   assign q_m1   = mqm1;
   assign a_sign = ma[8];
   assign obs = {ld_regs, add_en, sub_en, shift_en, shift_left,
                 qbit_en, qbit_val, busy, done, iter};

   initial begin
      ma = '0; mm = '0; mq = '0; mqm1 = 1'b0;
      opq = '0; opm = '0;
   end

   always @(posedge clk) begin
      if (ld_regs) begin
         ma <= '0; mq <= opq; mm <= opm; mqm1 <= 1'b0;
      end else begin
         if (add_en) ma <= ma + mm;
         else if (sub_en) ma <= ma - mm;
         if (shift_en) begin
            if (shift_left) {ma, mq} <= {ma[7:0], mq, 1'b0};
            else {ma, mq, mqm1} <= {ma[8], ma, mq};
         end
         if (qbit_en) mq[0] <= qbit_val;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      start = 1'b1;
      op = 2'b10;
      step();
      step();
      n_cmp++;
      if (obs !== 12'd0) begin
         n_bad++;
         $display("FAIL reset_hold got %b want %b", obs, 12'd0);
      end
      start = 1'b0;
      reset = 1'b1;
      step();
      n_cmp++;
      if (obs !== 12'd0) begin
         n_bad++;
         $display("FAIL reset_release got %b want %b", obs, 12'd0);
      end
   endtask

   task automatic test_addsub();
      logic [1:0] o;
      for (int k = 0; k < 2; k++) begin
         o = 2'(k);
         op = o;
         start = 1'b1;
         step();
         start = 1'b0;
         op = ~o;
         for (int c = 1; c <= 4; c++) begin
            case (c)
               1: exp_v = {9'b100000010, 3'd0};
               2: exp_v = {1'b0, ~o[0], o[0], 6'b000010, 3'd0};
               3: exp_v = {9'b000000011, 3'd0};
               default: exp_v = 12'd0;
            endcase
            n_cmp++;
            if (obs !== exp_v) begin
               n_bad++;
               $display("FAIL addsub op%0d c%0d got %b want %b",
                        k, c, obs, exp_v);
            end
            step();
         end
      end
   endtask

   task automatic test_mul();
      int shifts;
      int it;
      shifts = 0;
      opq = 8'd3;
      opm = 9'h1FE;
      op = 2'b10;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int c = 1; c <= 19; c++) begin
         it = (c - 2) / 2;
         if (c == 1) exp_v = {9'b100000010, 3'd0};
         else if (c <= 17 && (c % 2) == 0)
            exp_v = {1'b0, ~q0 & q_m1, q0 & ~q_m1, 6'b000010, 3'(it)};
         else if (c <= 17)
            exp_v = {9'b000100010, 3'(it)};
         else if (c == 18) exp_v = {9'b000000011, 3'd0};
         else exp_v = 12'd0;
         n_cmp++;
         if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL mul c%0d got %b want %b", c, obs, exp_v);
         end
         if (shift_en) shifts++;
         step();
      end
      n_cmp++;
      if (shifts != 8) begin
         n_bad++;
         $display("FAIL mul_shifts got %0d want 8", shifts);
      end
      n_cmp++;
      if ({ma[7:0], mq} !== 16'hFFFA) begin
         n_bad++;
         $display("FAIL mul_product got %h want fffa", {ma[7:0], mq});
      end
   endtask

   task automatic test_div(input string tag);
      int it;
      int k;
      opq = 8'd7;
      opm = 9'd2;
      op = 2'b11;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int c = 1; c <= 28; c++) begin
         it = (c - 2) / 3;
         k = (c - 2) % 3;
         if (c == 1) exp_v = {9'b100000010, 3'd0};
         else if (c <= 25 && k == 0)
            exp_v = {9'b000110010, 3'(it)};
         else if (c <= 25 && k == 1)
            exp_v = {1'b0, a_sign, ~a_sign, 6'b000010, 3'(it)};
         else if (c <= 25)
            exp_v = {5'b00000, 1'b1, ~a_sign, 2'b10, 3'(it)};
         else if (c == 26) exp_v = {1'b0, a_sign, 7'b0000010, 3'd0};
         else if (c == 27) exp_v = {9'b000000011, 3'd0};
         else exp_v = 12'd0;
         n_cmp++;
         if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s c%0d got %b want %b", tag, c, obs, exp_v);
         end
         step();
      end
      n_cmp++;
      if (mq !== 8'd3 || ma !== 9'd1) begin
         n_bad++;
         $display("FAIL %s_result got Q=%0d A=%0d want Q=3 A=1",
                  tag, mq, ma);
      end
   endtask

   task automatic test_back_to_back();
      int lds;
      lds = 0;
      opq = 8'd3;
      opm = 9'h1FE;
      op = 2'b10;
      start = 1'b1;
      step();
      for (int c = 1; c <= 18; c++) begin
         op = (c % 2 == 1) ? 2'b01 : 2'b11;
         if (ld_regs) lds++;
         n_cmp++;
         if ({busy, done, shift_left} !== {1'b1, c == 18, 1'b0}) begin
            n_bad++;
            $display("FAIL b2b c%0d busy/done/shl got %b want %b",
                     c, {busy, done, shift_left}, {1'b1, c == 18, 1'b0});
         end
         step();
      end
      n_cmp++;
      if (lds != 1 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL b2b_single got lds=%0d busy=%b want 1 0",
                  lds, busy);
      end
      op = 2'b00;
      step();
      start = 1'b0;
      n_cmp++;
      if ({ld_regs, busy} !== 2'b11) begin
         n_bad++;
         $display("FAIL b2b_reaccept got %b want 11", {ld_regs, busy});
      end
      step();
      n_cmp++;
      if ({add_en, sub_en} !== 2'b10) begin
         n_bad++;
         $display("FAIL b2b_add got %b want 10", {add_en, sub_en});
      end
      step();
      n_cmp++;
      if (done !== 1'b1) begin
         n_bad++;
         $display("FAIL b2b_done got %b want 1", done);
      end
      step();
   endtask

   task automatic test_abort();
      int dn;
      abort = 1'b1;
      step();
      n_cmp++;
      if (busy !== 1'b0) begin
         n_bad++;
         $display("FAIL abort_idle busy got %b want 0", busy);
      end
      opq = 8'd3;
      opm = 9'h1FE;
      op = 2'b10;
      start = 1'b1;
      step();
      start = 1'b0;
      abort = 1'b0;
      n_cmp++;
      if ({ld_regs, busy} !== 2'b11) begin
         n_bad++;
         $display("FAIL abort_startwins got %b want 11", {ld_regs, busy});
      end
      repeat (9) step();
      n_cmp++;
      if ({shift_en, busy, iter} !== {2'b01, 3'd4}) begin
         n_bad++;
         $display("FAIL abort_eval4 got %b want %b",
                  {shift_en, busy, iter}, {2'b01, 3'd4});
      end
      abort = 1'b1;
      step();
      abort = 1'b0;
      n_cmp++;
      if (obs !== 12'd0) begin
         n_bad++;
         $display("FAIL abort_idle_next got %b want %b", obs, 12'd0);
      end
      dn = 0;
      for (int c = 0; c < 25; c++) begin
         if (done || busy) dn++;
         step();
      end
      n_cmp++;
      if (dn != 0) begin
         n_bad++;
         $display("FAIL abort_quiet got %0d active cycles want 0", dn);
      end
      op = 2'b00;
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      n_cmp++;
      if ({done, busy} !== 2'b11) begin
         n_bad++;
         $display("FAIL abort_rerun got %b want 11", {done, busy});
      end
      step();
   endtask

   task automatic test_reset_mid();
      op = 2'b11;
      opq = 8'd7;
      opm = 9'd2;
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (18) step();
      n_cmp++;
      if ({qbit_en, iter} !== {1'b1, 3'd5}) begin
         n_bad++;
         $display("FAIL rst_mid_qbit5 got %b want %b",
                  {qbit_en, iter}, {1'b1, 3'd5});
      end
      #1 reset = 1'b0;
      #1;
      n_cmp++;
      if (obs !== 12'd0) begin
         n_bad++;
         $display("FAIL rst_mid_async got %b want %b", obs, 12'd0);
      end
      step();
      step();
      n_cmp++;
      if (obs !== 12'd0) begin
         n_bad++;
         $display("FAIL rst_mid_hold got %b want %b", obs, 12'd0);
      end
      reset = 1'b1;
      step();
      test_div("div_after_rst");
   endtask

   initial begin
      test_reset();
      test_addsub();
      test_mul();
      test_div("div");
      test_back_to_back();
      test_abort();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
